// File: rtl/led_bar_if.sv
// Bus between the 16-LED bar generator side and the bar monitor.
// The master drives the pattern and strobe; the slave returns the decoded status.
interface led_bar_if;
  logic [15:0] led_in;
  logic        sample;
  logic [4:0]  len;
  logic [3:0]  head;
  logic        locked;
  logic        err;
  logic        step_ok;
  logic        bad_pat;
  logic [7:0]  lap_count;
  logic [7:0]  err_count;

  modport master (
    output led_in, sample,
    input  len, head, locked, err, step_ok, bad_pat, lap_count, err_count
  );

  modport slave (
    input  led_in, sample,
    output len, head, locked, err, step_ok, bad_pat, lap_count, err_count
  );
endinterface

// File: rtl/led_bar_monitor.sv
// Receive-side checker for the rotating LED bar: decodes segment length/head
// and verifies each strobed pattern is the previous one rotated left by one.
module led_bar_monitor (
  input  logic      clk,
  input  logic      rst,
  led_bar_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ref_pat_q, ref_pat_d;
  logic [4:0]  len_q, len_d;
  logic [3:0]  head_q, head_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic        step_ok_q, step_ok_d;
  logic        bad_pat_q, bad_pat_d;
  logic [7:0]  lap_count_q, lap_count_d;
  logic [7:0]  err_count_q, err_count_d;

  logic [15:0] rise;
  logic [15:0] tail;
  logic [4:0]  n_rise;
  logic [4:0]  pop;
  logic [3:0]  tail_idx;
  logic        all_ones;
  logic        legal;
  logic [3:0]  new_head;
  logic        is_rot;

  // rise[i]: lit with dark right neighbour; tail[i]: lit with dark left neighbour.
  always_comb begin
    rise     = bus.led_in & ~{bus.led_in[14:0], bus.led_in[15]};
    tail     = bus.led_in & ~{bus.led_in[0], bus.led_in[15:1]};
    n_rise   = '0;
    pop      = '0;
    tail_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      n_rise = n_rise + {4'b0, rise[i]};
      pop    = pop + {4'b0, bus.led_in[i]};
      if (tail[i]) tail_idx = i[3:0];
    end
    all_ones = &bus.led_in;
    legal    = all_ones || (n_rise == 5'd1);
    new_head = all_ones ? 4'd15 : tail_idx;
    is_rot   = (bus.led_in == {ref_pat_q[14:0], ref_pat_q[15]});
  end

  always_comb begin
    state_d     = state_q;
    ref_pat_d   = ref_pat_q;
    len_d       = len_q;
    head_d      = head_q;
    step_ok_d   = 1'b0;
    bad_pat_d   = 1'b0;
    lap_count_d = lap_count_q;
    err_count_d = err_count_q;

    if (bus.sample) begin
      unique case (state_q)
        S_IDLE, S_ERR: begin
          if (legal) begin
            state_d   = S_TRACK;
            ref_pat_d = bus.led_in;
            len_d     = pop;
            head_d    = new_head;
          end else begin
            bad_pat_d = 1'b1;
          end
        end
        S_TRACK: begin
          if (is_rot) begin
            step_ok_d = 1'b1;
            ref_pat_d = bus.led_in;
            len_d     = pop;
            head_d    = new_head;
            if (head_q == 4'd15 && new_head == 4'd0)
              lap_count_d = lap_count_q + 8'd1;
          end else begin
            state_d   = S_ERR;
            bad_pat_d = !legal;
            if (err_count_q != 8'hFF)
              err_count_d = err_count_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    locked_d = (state_d == S_TRACK);
    err_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ref_pat_q   <= '0;
      len_q       <= '0;
      head_q      <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      step_ok_q   <= 1'b0;
      bad_pat_q   <= 1'b0;
      lap_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ref_pat_q   <= ref_pat_d;
      len_q       <= len_d;
      head_q      <= head_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      step_ok_q   <= step_ok_d;
      bad_pat_q   <= bad_pat_d;
      lap_count_q <= lap_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.len       = len_q;
  assign bus.head      = head_q;
  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.step_ok   = step_ok_q;
  assign bus.bad_pat   = bad_pat_q;
  assign bus.lap_count = lap_count_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_led_bar_monitor.sv
// Directed bench for led_bar_monitor: hand-computed expectations checked
// with immediate assertions after each strobed edge.
module tb_led_bar_monitor;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  led_bar_if bus ();

  led_bar_monitor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input int l, input int h, input int lk,
                    input int e, input int so, input int bp, input int lc, input int ec);
    chk({tag, ".len"},       8'(bus.len),       8'(l));
    chk({tag, ".head"},      8'(bus.head),      8'(h));
    chk({tag, ".locked"},    8'(bus.locked),    8'(lk));
    chk({tag, ".err"},       8'(bus.err),       8'(e));
    chk({tag, ".step_ok"},   8'(bus.step_ok),   8'(so));
    chk({tag, ".bad_pat"},   8'(bus.bad_pat),   8'(bp));
    chk({tag, ".lap_count"}, bus.lap_count,     8'(lc));
    chk({tag, ".err_count"}, bus.err_count,     8'(ec));
  endtask

  task automatic samp(input logic [15:0] p);
    bus.led_in = p;
    bus.sample = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.sample = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst(input logic smp, input logic [15:0] p);
    rst        = 1'b1;
    bus.sample = smp;
    bus.led_in = p;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.sample = 1'b0;
  endtask

  logic [15:0] p;

  initial begin
    rst        = 1'b1;
    bus.sample = 1'b0;
    bus.led_in = '0;
    repeat (2) @(posedge clk);
    #1;
    st("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // First lock and back-to-back rotation
    samp(16'h0007); st("lock7",  3, 2, 1, 0, 0, 0, 0, 0);
    samp(16'h000E); st("rot_e",  3, 3, 1, 0, 1, 0, 0, 0);
    samp(16'h001C); st("rot_1c", 3, 4, 1, 0, 1, 0, 0, 0);
    idle();         st("hold",   3, 4, 1, 0, 0, 0, 0, 0);

    // Head wrap 15 -> 0
    do_rst(1'b0, 16'h0000);
    samp(16'hE000); st("lockE000", 3, 15, 1, 0, 0, 0, 0, 0);
    samp(16'hC001); st("wrap",     3, 0,  1, 0, 1, 0, 1, 0);
    samp(16'h8003); st("rot8003",  3, 1,  1, 0, 1, 0, 1, 0);
    samp(16'h0007); st("rot0007",  3, 2,  1, 0, 1, 0, 1, 0);
    samp(16'h000E); st("rot000e",  3, 3,  1, 0, 1, 0, 1, 0);

    // Mismatch, then relock without rotation check
    samp(16'h0038); st("mismatch", 3, 3, 0, 1, 0, 0, 1, 1);
    samp(16'h0070); st("relock",   3, 6, 1, 0, 0, 0, 1, 1);

    p = 16'h0070;
    for (int i = 0; i < 10; i++) begin
      p = {p[14:0], p[15]};
      samp(p);
      chk("run.step_ok", 8'(bus.step_ok), 8'd1);
    end
    st("lap2", 3, 0, 1, 0, 1, 0, 2, 1);

    // Reset has priority over a concurrent sample
    do_rst(1'b1, 16'h0007);
    st("rst_w_sample", 0, 0, 0, 0, 0, 0, 0, 0);
    samp(16'h0007); st("relock_rst", 3, 2, 1, 0, 0, 0, 0, 0);

    // Illegal in TRACK counts; illegal in ERR does not
    samp(16'h0005); st("ill_track", 3, 2, 0, 1, 0, 1, 0, 1);
    samp(16'h0000); st("ill_err",   3, 2, 0, 1, 0, 1, 0, 1);
    samp(16'h00F0); st("relock4",   4, 7, 1, 0, 0, 0, 0, 1);

    // Illegal patterns from IDLE, then the all-ones fixed point
    do_rst(1'b0, 16'h0000);
    samp(16'h0005); st("idle_0005", 0, 0, 0, 0, 0, 1, 0, 0);
    samp(16'h0000); st("idle_0000", 0, 0, 0, 0, 0, 1, 0, 0);
    idle();         st("idle_gap",  0, 0, 0, 0, 0, 0, 0, 0);
    samp(16'hFFFF); st("ones_lock", 16, 15, 1, 0, 0, 0, 0, 0);
    samp(16'hFFFF); st("ones_step", 16, 15, 1, 0, 1, 0, 0, 0);

    // err_count saturation: alternating relock / mismatch on 0x0007
    samp(16'h0007); st("sat_first", 16, 15, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      samp(16'h0007);
      samp(16'h0007);
    end
    st("sat", 3, 2, 0, 1, 0, 0, 0, 255);

    // lap_count wraps 255 -> 0
    do_rst(1'b0, 16'h0000);
    samp(16'h0001); st("lock1", 1, 0, 1, 0, 0, 0, 0, 0);
    p = 16'h0001;
    for (int i = 0; i < 255 * 16; i++) begin
      p = {p[14:0], p[15]};
      samp(p);
    end
    st("lap255", 1, 0, 1, 0, 1, 0, 255, 0);
    for (int i = 0; i < 16; i++) begin
      p = {p[14:0], p[15]};
      samp(p);
    end
    st("lapwrap", 1, 0, 1, 0, 1, 0, 0, 0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
